toggle_counter: RTL and testbench
=================================

TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the width of the toggle count register.
REQ-002 Parameter WIN_W, default 8, SHALL set the width of the window length and window counter.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: asynchronous and active-high.
REQ-005 Port start, input, 1 bit, SHALL request a new measurement window.
REQ-006 Port win_len, input, WIN_W bits, SHALL give the window length in clk cycles, sampled only when start is accepted.
REQ-007 Port q_in, input, 1 bit, SHALL carry the toggle flip-flop output (the q of the upstream stage), synchronous to clk.
REQ-008 Port count, output, WIDTH bits, SHALL give the number of q_in transitions seen in the last or current window.
REQ-009 Port busy, output, 1 bit, SHALL be high while a window is open.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle pulse marking window completion.
REQ-011 Port ovf, output, 1 bit, SHALL be a sticky flag marking count saturation within the current or last window.

Function
REQ-012 The block SHALL register q_in into q_d every cycle, regardless of state; edge = q_in XOR q_d; both rising and falling transitions count.
REQ-013 The FSM SHALL have states IDLE, COUNT and DONE, encoded in registers; all outputs SHALL be registered or decoded from state only.
REQ-014 In IDLE, if start=1 and win_len!=0, the block SHALL load win_cnt=win_len, clear count and ovf, and enter COUNT.
REQ-015 In IDLE, if start=1 and win_len=0, the block SHALL clear count and ovf and enter DONE directly.
REQ-016 In COUNT, edge=1 SHALL increment count by 1 in every cycle.
REQ-017 In COUNT, win_cnt SHALL decrement once per cycle; the cycle in which win_cnt=1 SHALL be the last counted cycle, followed by a transition to DONE.
REQ-018 Timing: if start is accepted in cycle N, edges SHALL be evaluated in cycles N+1 .. N+win_len, and done SHALL be high in cycle N+win_len+1 only.
REQ-019 An edge in the start-acceptance cycle N SHALL NOT be counted.
REQ-020 At all-ones, count SHALL saturate, not wrap; a further edge SHALL set ovf=1, and ovf SHALL hold until the next accepted start or reset.
REQ-021 busy SHALL be 1 exactly in COUNT; done SHALL be 1 exactly in DONE; DONE SHALL always return to IDLE after one cycle.
REQ-022 start SHALL be ignored in COUNT and DONE; it is not queued.
REQ-023 count and ovf SHALL hold their values in DONE and IDLE until the next accepted start.
REQ-024 win_len changes outside start acceptance SHALL have no effect.

Reset
REQ-025 While rst=1, asynchronously: state=IDLE, count=0, ovf=0, busy=0, done=0, win_cnt=0, q_d=0.
REQ-026 A reset during COUNT SHALL abort the window with no done pulse; the first start after rst falls SHALL behave per REQ-014/015.

Verification
REQ-027 Reset: assert rst mid-cycle with clk running -> count=0, busy=0, done=0, ovf=0 immediately, before the next clk edge.
REQ-028 Full toggle: TFF upstream with t=1 drives q_in; start at N with win_len=10 -> busy in N+1..N+10, count=10, done high only in N+11, ovf=0.
REQ-029 No toggle: q_in held 1; start with win_len=5 -> count=0, done at N+6; a q_in toggle in cycle N alone leaves count=0.
REQ-030 Saturation: WIDTH=4, win_len=20, q_in toggles every cycle -> count=15, ovf=1 at done; the next start clears ovf to 0.
REQ-031 Zero window: start with win_len=0 -> done high at N+1, busy never high, count=0.
REQ-032 Abort/ignore:
- start pulsed again during COUNT -> window length unchanged.
- rst pulsed at N+3 of a 10-cycle window -> no done, count=0.
- A new start after reset (win_len=4, toggle every cycle) -> count=4.

Source files
------------

// File: rtl/toggle_counter.sv
// toggle_counter: counts transitions of an upstream toggle flip-flop output
// over a programmable window of clk cycles.
//
// Ports:
//   clk     - single clock, rising edge
//   rst     - asynchronous active-high reset
//   start   - request a new window (accepted only in IDLE)
//   win_len - window length in cycles, sampled on start acceptance
//   q_in    - upstream toggle flop output, synchronous to clk
//   count   - transitions seen in the current or last window (saturating)
//   busy    - high while the window is open
//   done    - one-cycle pulse after the last counted cycle
//   ovf     - sticky: an edge arrived while count was already saturated
module toggle_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             q_in,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic               q_in_q;
  logic               edge_det;

  // q_in_q tracks q_in every cycle in every state, so the first counted
  // cycle compares against the value seen in the start-acceptance cycle.
  assign edge_det = q_in ^ q_in_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    win_cnt_d = win_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          ovf_d   = 1'b0;
          if (win_len != '0) begin
            win_cnt_d = win_len;
            state_d   = COUNT;
          end else begin
            state_d = DONE;
          end
        end
      end
      COUNT: begin
        if (edge_det) begin
          if (count_q == '1) ovf_d = 1'b1;
          else               count_d = count_q + WIDTH'(1);
        end
        win_cnt_d = win_cnt_q - WIN_W'(1);
        if (win_cnt_q == WIN_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      win_cnt_q <= '0;
      q_in_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      win_cnt_q <= win_cnt_d;
      q_in_q    <= q_in;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == COUNT);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_toggle_counter.sv
module tb_toggle_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] win_len;
  logic       q_in;
  logic [7:0] count8;
  logic [3:0] count4;
  logic       busy8, done8, ovf8, busy4, done4, ovf4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(8), .WIN_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .q_in(q_in),
    .count(count8), .busy(busy8), .done(done8), .ovf(ovf8)
  );

  toggle_counter #(.WIDTH(4), .WIN_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .q_in(q_in),
    .count(count4), .busy(busy4), .done(done4), .ovf(ovf4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic next_q(input int mode, input logic cur);
    if (mode == 0)      return ~cur;
    else if (mode == 1) return 1'b1;
    else                return 1'($urandom_range(0, 1));
  endfunction

  // One window: start in cycle N, expect busy in N+1..N+L, done only in
  // N+L+1, count = transitions between consecutive cycles N..N+L, saturated.
  task automatic run_window(input int len, input int mode, input bit poke);
    int         tr;
    logic       prev;
    logic [7:0] e8;
    logic [3:0] e4;
    logic       eo8, eo4;
    start   = 1'b1;
    win_len = len[7:0];
    q_in    = next_q(mode, q_in);
    prev    = q_in;
    tr      = 0;
    step();
    start   = 1'b0;
    win_len = 8'($urandom);
    for (int k = 1; k <= len; k++) begin
      n_checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || busy4 !== 1'b1 || done4 !== 1'b0) begin
        n_fail++;
        $display("FAIL window_busy len=%0d cyc=N+%0d: busy8=%b done8=%b busy4=%b done4=%b required busy=1 done=0",
                 len, k, busy8, done8, busy4, done4);
      end
      if (poke && k == 2) begin
        start   = 1'b1;
        win_len = 8'd3;
      end else begin
        start = 1'b0;
      end
      q_in = next_q(mode, q_in);
      if (q_in !== prev) tr++;
      prev = q_in;
      step();
    end
    start = 1'b0;
    e8  = (tr > 255) ? 8'hFF : tr[7:0];
    eo8 = (tr > 255);
    e4  = (tr > 15) ? 4'hF : tr[3:0];
    eo4 = (tr > 15);
    n_checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || done4 !== 1'b1 || busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL window_done len=%0d: done8=%b busy8=%b done4=%b busy4=%b required done=1 busy=0",
               len, done8, busy8, done4, busy4);
    end
    n_checks++;
    if (count8 !== e8 || ovf8 !== eo8) begin
      n_fail++;
      $display("FAIL count8 len=%0d: count=%0d ovf=%b required count=%0d ovf=%b", len, count8, ovf8, e8, eo8);
    end
    n_checks++;
    if (count4 !== e4 || ovf4 !== eo4) begin
      n_fail++;
      $display("FAIL count4 len=%0d: count=%0d ovf=%b required count=%0d ovf=%b", len, count4, ovf4, e4, eo4);
    end
    q_in = 1'($urandom_range(0, 1));
    step();
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || done4 !== 1'b0 || busy4 !== 1'b0 ||
        count8 !== e8 || ovf8 !== eo8 || count4 !== e4 || ovf4 !== eo4) begin
      n_fail++;
      $display("FAIL after_done len=%0d: done8=%b busy8=%b count8=%0d ovf8=%b count4=%0d ovf4=%b required done=0 busy=0 count8=%0d count4=%0d",
               len, done8, busy8, count8, ovf8, count4, ovf4, e8, e4);
    end
  endtask

  task automatic check_zero(input string tag);
    n_checks++;
    if (count8 !== 8'd0 || busy8 !== 1'b0 || done8 !== 1'b0 || ovf8 !== 1'b0 ||
        count4 !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || ovf4 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: count8=%0d busy8=%b done8=%b ovf8=%b count4=%0d busy4=%b done4=%b ovf4=%b required all 0",
               tag, count8, busy8, done8, ovf8, count4, busy4, done4, ovf4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; win_len = 8'd0; q_in = 1'b0;
    #3;
    check_zero("reset_initial");
    step();
    step();
    rst = 1'b0;
    step();
    check_zero("reset_released");
  endtask

  task automatic test_full_toggle();
    run_window(10, 0, 1'b0);
  endtask

  task automatic test_no_toggle();
    // q_in rises in the start cycle only, then holds 1: nothing counted
    q_in = 1'b0;
    step();
    run_window(5, 1, 1'b0);
  endtask

  task automatic test_saturation();
    run_window(20, 0, 1'b0);
    run_window(3, 0, 1'b0);
  endtask

  task automatic test_zero_window();
    run_window(0, 2, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_window(10, 0, 1'b1);
  endtask

  task automatic test_abort();
    start = 1'b1; win_len = 8'd10; q_in = ~q_in;
    step();
    start = 1'b0;
    q_in = ~q_in; step();
    q_in = ~q_in; step();
    q_in = ~q_in;
    #3 rst = 1'b1;
    #1 check_zero("abort_async_reset");
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      q_in = ~q_in;
      step();
      check_zero("abort_no_done");
    end
    run_window(4, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        q_in = 1'($urandom_range(0, 1));
        win_len = 8'($urandom);
        step();
      end
      run_window(int'($urandom_range(0, 30)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_full_toggle();
    test_no_toggle();
    test_saturation();
    test_zero_window();
    test_start_ignored();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
